// File: rtl/shift_reg_param_pkg.sv
// Shared types for shift_reg_param: per-edge operation encoding and its priority decode.
// OP_ROT is only reachable when SHIFT_REG_PARAM_ROTATE_EN is defined.
package shift_reg_param_pkg;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_SHIFT,
    OP_LOAD,
    OP_FLUSH,
    OP_ROT
  } op_e;

  // Priority: flush > load > en; rot only changes what an enabled edge does.
  function automatic op_e decode_op(input logic flush, input logic load,
                                    input logic en, input logic rot);
    op_e op;
    if (flush)     op = OP_FLUSH;
    else if (load) op = OP_LOAD;
    else if (en)   op = rot ? OP_ROT : OP_SHIFT;
    else           op = OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/shift_reg_param_if.sv
// Control/data bundle for shift_reg_param; master drives controls, slave is the register.
// The rot signal exists only when SHIFT_REG_PARAM_ROTATE_EN is defined.
interface shift_reg_param_if #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
);
  localparam int FW = $clog2(DEPTH + 1);

  logic                   en;
  logic                   load;
  logic [DEPTH*WIDTH-1:0] load_data;
  logic                   flush;
  logic [WIDTH-1:0]       in;
  logic [WIDTH-1:0]       out;
  logic [DEPTH*WIDTH-1:0] taps;
  logic [FW-1:0]          fill;
  logic                   full;
`ifdef SHIFT_REG_PARAM_ROTATE_EN
  logic                   rot;
`endif

  modport master (
    output en, load, load_data, flush, in,
`ifdef SHIFT_REG_PARAM_ROTATE_EN
    output rot,
`endif
    input  out, taps, fill, full
  );

  modport slave (
    input  en, load, load_data, flush, in,
`ifdef SHIFT_REG_PARAM_ROTATE_EN
    input  rot,
`endif
    output out, taps, fill, full
  );

endinterface

// File: rtl/shift_reg_stage.sv
// One WIDTH-bit stage of shift_reg_param: hold, take its shift input, load, or clear.
module shift_reg_stage
  import shift_reg_param_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  op_e              op,
  input  logic [WIDTH-1:0] shift_d,
  input  logic [WIDTH-1:0] load_d,
  output logic [WIDTH-1:0] q
);

  // NOTE: non-blocking (<=) so every stage samples its neighbour's pre-edge value;
  // blocking here would collapse the chain into one cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q <= '0;
    end else begin
      unique case (op)
        OP_FLUSH:         q <= '0;
        OP_LOAD:          q <= load_d;
        OP_SHIFT, OP_ROT: q <= shift_d;
        default:          q <= q;
      endcase
    end
  end

endmodule

// File: rtl/shift_reg_param.sv
// Parametrised WIDTH x DEPTH shift register with parallel load, flush and fill tracking.
// Define SHIFT_REG_PARAM_ROTATE_EN to add the rot input (stage DEPTH-1 feeds stage 0).
module shift_reg_param
  import shift_reg_param_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               resetn,
  shift_reg_param_if.slave   bus
);

  localparam int            FW       = $clog2(DEPTH + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

  op_e              op;
  logic             rot_sel;
  logic [WIDTH-1:0] head_d;
  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [FW-1:0]    fill_q;

`ifdef SHIFT_REG_PARAM_ROTATE_EN
  assign rot_sel = bus.rot;
  assign head_d  = (op == OP_ROT) ? stage_q[DEPTH-1] : bus.in;
`else
  assign rot_sel = 1'b0;
  assign head_d  = bus.in;
`endif

  assign op = decode_op(bus.flush, bus.load, bus.en, rot_sel);

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] shift_d;

    if (k == 0) begin : g_head
      assign shift_d = head_d;
    end else begin : g_body
      assign shift_d = stage_q[k-1];
    end

    shift_reg_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .resetn  (resetn),
      .op      (op),
      .shift_d (shift_d),
      .load_d  (bus.load_data[k*WIDTH +: WIDTH]),
      .q       (stage_q[k])
    );

    assign bus.taps[k*WIDTH +: WIDTH] = stage_q[k];
  end

  // A rotate recirculates existing data, so it never changes how many stages are valid.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fill_q <= '0;
    end else begin
      unique case (op)
        OP_FLUSH: fill_q <= '0;
        OP_LOAD:  fill_q <= FILL_MAX;
        OP_SHIFT: if (fill_q != FILL_MAX) fill_q <= fill_q + FW'(1);
        default:  fill_q <= fill_q;
      endcase
    end
  end

  assign bus.out  = stage_q[DEPTH-1];
  assign bus.fill = fill_q;
  assign bus.full = (fill_q == FILL_MAX);

endmodule
